bfm_ahbslave_mem: RTL and testbench

BFM_AHBSLAVE_MEM -- requirements
Module: bfm_ahbslave_mem

---
 rtl/bfm_ahb_pkg.sv | 51 +++++
 rtl/bfm_ahbslave_mem_ram.sv | 43 ++++
 rtl/bfm_ahbslave_mem.sv | 156 +++++++++++++++
 tb/tb_bfm_ahbslave_mem.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfm_ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and byte-lane helpers for the
// bfm_ahbslave_mem memory model.
package bfm_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Low address bits that must be zero for a naturally aligned transfer.
  function automatic logic [2:0] size_low_bits(input logic [2:0] size);
    case (size)
      HSIZE_BYTE: return 3'b000;
      HSIZE_HALF: return 3'b001;
      HSIZE_WORD: return 3'b011;
      default:    return 3'b111;
    endcase
  endfunction

  // Byte lanes touched by a transfer; misaligned low bits are truncated.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lo);
    logic [7:0] base;
    logic [2:0] start;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    start = lo & ~size_low_bits(size);
    return base << start;
  endfunction

endpackage

// File: rtl/bfm_ahbslave_mem_ram.sv
// Word-organised memory with byte enables, one registered read port and
// write-to-read bypass when both ports hit the same word on the same edge.
module bfm_ahbslave_mem_ram #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DWIDTH/8-1:0] wmask_i,
  input  logic [DWIDTH-1:0]   wdata_i,
  input  logic                re_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [DWIDTH-1:0]   rdata_o
);
  localparam int NB = DWIDTH / 8;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] merged;

  // NOTE: blocking (=) in combinational blocks, non-blocking (<=) in clocked ones.
  always_comb begin
    merged = mem_q[waddr_i];
    for (int b = 0; b < NB; b++) begin
      if (wmask_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // NOTE: the array and its read register have no reset; contents survive HRESET.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= (we_i && (raddr_i == waddr_i)) ? merged : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bfm_ahbslave_mem.sv
// AHB-Lite slave memory BFM with programmable wait states and a transfer counter.
// Define BFM_AHBSLAVE_MEM_ERRRESP_EN to enable two-cycle ERROR responses.
module bfm_ahbslave_mem
  import bfm_ahb_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 256,
  parameter int WAITS  = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADYIN,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [15:0]       XFERCNT
);
  localparam int NB  = DWIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = AWIDTH - LSB;
  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef BFM_AHBSLAVE_MEM_ERRRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            dp_write_q;
  logic [RAW-1:0]  dp_addr_q;
  logic [NB-1:0]   dp_mask_q;
  logic [15:0]     xfercnt_q;

  logic            accept, ready, xfer_err;
  logic            size_big, misaligned, out_of_range;
  logic [IW-1:0]   word_idx;
  logic [2:0]      lo, eff_size;
  logic [RAW-1:0]  ram_addr;
  logic [NB-1:0]   lane_en;
  logic            ram_we, ram_re;
  logic [DWIDTH-1:0] ram_rdata;

  // Address-phase decode; without error responses, oversize is clamped and the index wraps.
  always_comb begin
    word_idx     = HADDR[AWIDTH-1:LSB];
    lo           = 3'(HADDR[LSB-1:0]);
    size_big     = HSIZE > 3'(LSB);
    eff_size     = size_big ? 3'(LSB) : HSIZE;
    misaligned   = |(lo & size_low_bits(HSIZE));
    out_of_range = 32'(word_idx) >= 32'(DEPTH);
    ram_addr     = RAW'(32'(word_idx) % 32'(DEPTH));
    lane_en      = NB'(lane_mask(eff_size, lo));
    xfer_err     = ERR_EN & (size_big | misaligned | out_of_range);
    accept       = HSEL & HREADYIN & ready &
                   ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // NOTE: defaults first so every path assigns each output, which prevents latches.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_DATA;
        else              wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (xfer_err) begin
          state_d = ST_ERR1;
        end else if (WAITS > 0) begin
          state_d = ST_WAIT;
          wcnt_d  = 4'(WAITS - 1);
        end else begin
          state_d = ST_DATA;
        end
      end
    endcase
  end

  always_comb begin
    ready  = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (state_q)
      ST_WAIT: ready = 1'b0;
      ST_DATA: if (!dp_write_q) HRDATA = ram_rdata;
      ST_ERR1: begin
        ready = 1'b0;
        HRESP = ERR_EN;
      end
      ST_ERR2: HRESP = ERR_EN;
      default: ;
    endcase
  end

  assign HREADYOUT = ready;

  // Data-phase context; the write itself commits on the final DATA edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_mask_q  <= '0;
      xfercnt_q  <= '0;
    end else begin
      if (accept) begin
        dp_write_q <= HWRITE;
        dp_addr_q  <= ram_addr;
        dp_mask_q  <= lane_en;
      end
      if (state_q == ST_DATA) xfercnt_q <= xfercnt_q + 16'd1;
    end
  end

  assign ram_we  = (state_q == ST_DATA) & dp_write_q;
  assign ram_re  = accept & ~HWRITE & ~xfer_err;
  assign XFERCNT = xfercnt_q;

  bfm_ahbslave_mem_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (RAW)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (ram_we),
    .waddr_i (dp_addr_q),
    .wmask_i (dp_mask_q),
    .wdata_i (HWDATA),
    .re_i    (ram_re),
    .raddr_i (ram_addr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_bfm_ahbslave_mem.sv
// Bench for bfm_ahbslave_mem: two instances (0 and 3 wait states) checked
// against a byte-addressed memory model under directed and random traffic.
module tb_bfm_ahbslave_mem;

  typedef struct {
    bit          write;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          gap;
    bit          seq;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel      [2];
  logic [11:0] haddr     [2];
  logic        hwrite    [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hreadyin  [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [15:0] xfercnt   [2];

  logic [7:0]  mem_b   [2][1024];
  logic [15:0] xcnt_m  [2];
  logic [31:0] last_rd [2];
  int          last_lows [2];
  bit          last_resp [2];
  xfer_t       q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign hreadyin[0] = hreadyout[0];
  assign hreadyin[1] = hreadyout[1];

  bfm_ahbslave_mem #(.AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WAITS(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADYIN(hreadyin[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .XFERCNT(xfercnt[0])
  );

  bfm_ahbslave_mem #(.AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WAITS(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADYIN(hreadyin[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .XFERCNT(xfercnt[1])
  );

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] model_word(input int d, input int w);
    return {mem_b[d][4*w+3], mem_b[d][4*w+2], mem_b[d][4*w+1], mem_b[d][4*w]};
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [11:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
    xfer_t t;
    t.write = wr; t.addr = a; t.size = sz; t.wdata = wd; t.gap = 1'b0; t.seq = 1'b0;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
    check("rst_hresp",     32'(hresp[d]),     32'd0);
    check("rst_hrdata",    hrdata[d],         32'd0);
    check("rst_xfercnt",   32'(xfercnt[d]),   32'd0);
  endtask

  // Retire one data phase against the byte-addressed model.
  task automatic complete(input int d, input xfer_t t, input int lows);
    int  a;
    int  nb;
    int  base;
    bit  err;
    a   = int'(t.addr);
    nb  = 1 << int'(t.size);
    err = 1'b0;
`ifdef BFM_AHBSLAVE_MEM_ERRRESP_EN
    err = (t.size > 3'd2) || ((a % nb) != 0) || ((a >> 2) >= 256);
`endif
    if (nb > 4) nb = 4;
    last_lows[d] = lows;
    last_resp[d] = err;
    check("wait_cycles", 32'(lows), err ? 32'd1 : 32'(waits_of(d)));
    check("hresp", 32'(hresp[d]), 32'(err));
    if (err) begin
      check("rdata_err_zero", hrdata[d], 32'd0);
    end else begin
      xcnt_m[d] = xcnt_m[d] + 16'd1;
      base = (a & ~(nb - 1)) % 1024;
      if (t.write) begin
        for (int k = 0; k < nb; k++) mem_b[d][base+k] = t.wdata[8*((base+k)%4) +: 8];
      end else begin
        check("rdata", hrdata[d], model_word(d, base / 4));
        last_rd[d] = hrdata[d];
      end
    end
  endtask

  // Drive the queued transfers as a pipelined AHB sequence on instance d.
  task automatic do_xfers(input int d);
    int    i = 0;
    bit    dp_valid = 1'b0;
    xfer_t dp;
    int    lows = 0;
    bit    gap_done = 1'b0;
    int    cyc = 0;
    int    budget;
    bit    present;
    budget = q.size() * (waits_of(d) + 4) + 20;
    while (i < q.size() || dp_valid) begin
      present = (i < q.size()) && (!q[i].gap || gap_done);
      hsel[d] = (i < q.size());
      if (i < q.size()) begin
        haddr[d]  = q[i].addr;
        hwrite[d] = q[i].write;
        hsize[d]  = q[i].size;
        htrans[d] = present ? (q[i].seq ? 2'b11 : 2'b10) : 2'b01;
      end else begin
        htrans[d] = 2'b00;
      end
      hwdata[d] = (dp_valid && dp.write) ? dp.wdata : $urandom();
      @(negedge clk);
      if (dp_valid && !hreadyout[d]) begin
        lows++;
        check("rdata_zero_in_wait", hrdata[d], 32'd0);
      end
      if (hreadyout[d]) begin
        if (dp_valid) complete(d, dp, lows);
        if (present) begin
          dp = q[i]; dp_valid = 1'b1; i++; gap_done = 1'b0; lows = 0;
        end else begin
          dp_valid = 1'b0;
          if (i < q.size()) gap_done = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > budget) begin
        n_cmp++; n_bad++;
        $error("FAIL timeout: instance %0d stuck after %0d cycles, expected completion", d, cyc);
        break;
      end
    end
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    q.delete();
  endtask

  initial begin
    logic [31:0] old;
    logic [15:0] cnt_before;
    xfer_t       t;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = '0; hwrite[d] = 1'b0; htrans[d] = 2'b00;
      hsize[d] = 3'd2; hwdata[d] = '0; xcnt_m[d] = '0; last_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write then read on the zero-wait slave.
    q.push_back(mk(1'b1, 12'h010, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 12'h010, 3'd2, 32'h0));
    do_xfers(0);
    check("s1_rdata",   last_rd[0],        32'hDEADBEEF);
    check("s1_no_wait", 32'(last_lows[0]), 32'd0);
    check("s1_xfercnt", 32'(xfercnt[0]),   32'd2);

    // Fill both memories so every later read has a defined expectation.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++) q.push_back(mk(1'b1, 12'(4*w), 3'd2, $urandom()));
      do_xfers(d);
      check("init_xfercnt", 32'(xfercnt[d]), 32'(xcnt_m[d]));
    end

    // Single read with three wait states.
    q.push_back(mk(1'b0, 12'h084, 3'd2, 32'h0));
    do_xfers(1);
    check("s2_wait3", 32'(last_lows[1]), 32'd3);

    // Byte write into the top lane of a known word.
    for (int d = 0; d < 2; d++) begin
      q.push_back(mk(1'b1, 12'h010, 3'd2, 32'h11223344));
      q.push_back(mk(1'b1, 12'h013, 3'd0, {8'hAA, 24'($urandom())}));
      q.push_back(mk(1'b0, 12'h010, 3'd2, 32'h0));
      do_xfers(d);
      check("s3_byte_merge", last_rd[d], 32'hAA223344);
    end

    // Back-to-back write/read of the same word relies on the bypass.
    q.push_back(mk(1'b1, 12'h020, 3'd2, 32'h00000005));
    q.push_back(mk(1'b0, 12'h020, 3'd2, 32'h0));
    do_xfers(0);
    check("s4_bypass", last_rd[0],        32'h00000005);
    check("s4_nostall", 32'(last_lows[0]), 32'd0);

    // Word 300 on a 256-word memory.
    cnt_before = xcnt_m[0];
    q.push_back(mk(1'b0, 12'h4B0, 3'd2, 32'h0));
    do_xfers(0);
`ifdef BFM_AHBSLAVE_MEM_ERRRESP_EN
    check("s5_err_resp",   32'(last_resp[0]), 32'd1);
    check("s5_err1_cycle", 32'(last_lows[0]), 32'd1);
    check("s5_cnt_hold",   32'(xfercnt[0]),   32'(cnt_before));
`else
    check("s5_wrap_word44", last_rd[0], model_word(0, 44));
    check("s5_cnt",         32'(xfercnt[0]), 32'(cnt_before + 16'd1));
`endif

    // Random traffic: sizes incl. oversize, some misaligned, some out of range, idle gaps.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        t.write = 1'($urandom_range(0, 1));
        t.size  = 3'($urandom_range(0, 3));
        t.addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095))
                                             : 12'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~12'((1 << int'(t.size)) - 1);
        t.wdata = $urandom();
        t.gap   = ($urandom_range(0, 3) == 0);
        t.seq   = 1'($urandom_range(0, 1));
        q.push_back(t);
      end
      do_xfers(d);
      check("rand_xfercnt", 32'(xfercnt[d]), 32'(xcnt_m[d]));
    end

    // Reset while a write sits in its wait states: it must not commit.
    old = model_word(1, 16);
    hsel[1] = 1'b1; haddr[1] = 12'h040; hwrite[1] = 1'b1; htrans[1] = 2'b10;
    hsize[1] = 3'd2; hwdata[1] = '0;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = ~old;
    @(posedge clk); #1;
    check("s6_in_wait", 32'(hreadyout[1]), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset(1);
    check_reset(0);
    xcnt_m[0] = '0;
    xcnt_m[1] = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    q.push_back(mk(1'b0, 12'h040, 3'd2, 32'h0));
    do_xfers(1);
    check("s6_mem_kept", last_rd[1],         old);
    check("s6_xfercnt",  32'(xfercnt[1]),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
